riscv_load_wb_queue: RTL and testbench

//  In-order tracking queue for outstanding loads; drains returned load data into write port B
//  of the register file. Sits between the LSU and the register file: ID issues a load's rd, LSU

---
 rtl/riscv_load_wb_queue.sv | 112 +++++++++++
 tb/tb_riscv_load_wb_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_load_wb_queue.sv
// In-order queue of outstanding load rds; LSU responses are written to regfile port B, one cycle after they are accepted.
// Stalls issue when DEPTH loads are outstanding (issue_ready_o low); responses are never back-pressured, and an unmatched response raises err_o.
module riscv_load_wb_queue #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid_i,
    input  logic [ADDR_WIDTH-1:0]        issue_rd_i,
    output logic                         issue_ready_o,
    input  logic                         rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]        rsp_data_i,
    output logic [ADDR_WIDTH-1:0]        waddr_b_o,
    output logic [DATA_WIDTH-1:0]        wdata_b_o,
    output logic                         we_b_o,
    output logic [2**ADDR_WIDTH-1:0]     busy_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] rd_q [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_d [DEPTH];
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  we_b_q, we_b_d;
    logic [ADDR_WIDTH-1:0] waddr_b_q, waddr_b_d;
    logic [DATA_WIDTH-1:0] wdata_b_q, wdata_b_d;
    logic                  err_q, err_d;
    logic                  issue_acc, rsp_acc;

    assign issue_ready_o = (count_q < CW'(DEPTH));
    assign issue_acc     = issue_valid_i && issue_ready_o;
    assign rsp_acc       = rsp_valid_i && (count_q != '0);

    always_comb begin
        rd_d      = rd_q;
        vld_d     = vld_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        we_b_d    = 1'b0;
        waddr_b_d = waddr_b_q;
        wdata_b_d = wdata_b_q;
        err_d     = rsp_valid_i && (count_q == '0);

        if (issue_acc) begin
            rd_d[wr_ptr_q]  = issue_rd_i;
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        // Pop can never hit the slot just written: a pop needs a non-empty queue, a push a non-full one.
        if (rsp_acc) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
            we_b_d          = (rd_q[rd_ptr_q] != '0);
            waddr_b_d       = rd_q[rd_ptr_q];
            wdata_b_d       = rsp_data_i;
        end

        case ({issue_acc, rsp_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
            vld_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            we_b_q    <= 1'b0;
            waddr_b_q <= '0;
            wdata_b_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            vld_q     <= vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            we_b_q    <= we_b_d;
            waddr_b_q <= waddr_b_d;
            wdata_b_q <= wdata_b_d;
            err_q     <= err_d;
        end
    end

    // A register stays busy while queued or while its write is on port B this cycle.
    always_comb begin
        busy_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) busy_o[rd_q[i]] = 1'b1;
        end
        if (we_b_q) busy_o[waddr_b_q] = 1'b1;
        busy_o[0] = 1'b0;
    end

    assign we_b_o    = we_b_q;
    assign waddr_b_o = waddr_b_q;
    assign wdata_b_o = wdata_b_q;
    assign count_o   = count_q;
    assign err_o     = err_q;
endmodule

// File: tb/tb_riscv_load_wb_queue.sv
// Directed and random bench for riscv_load_wb_queue against a queue-based reference model.
module tb_riscv_load_wb_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic [4:0]  issue_rd_i = '0;
    logic        issue_ready_o;
    logic        rsp_valid_i = 1'b0;
    logic [31:0] rsp_data_i = '0;
    logic [4:0]  waddr_b_o;
    logic [31:0] wdata_b_o;
    logic        we_b_o;
    logic [31:0] busy_o;
    logic [2:0]  count_o;
    logic        err_o;

    riscv_load_wb_queue #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
        .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
        .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .we_b_o(we_b_o),
        .busy_o(busy_o), .count_o(count_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: outstanding rds in issue order plus the expected port-B state.
    logic [4:0]  mq[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    logic        m_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        foreach (mq[i]) b[mq[i]] = 1'b1;
        if (m_we) b[m_waddr] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 64'(count_o), 64'(mq.size()));
        chk({tag, ".ready"}, 64'(issue_ready_o), 64'(mq.size() < DEPTH));
        chk({tag, ".we"}, 64'(we_b_o), 64'(m_we));
        chk({tag, ".err"}, 64'(err_o), 64'(m_err));
        chk({tag, ".busy"}, 64'(busy_o), 64'(model_busy()));
        if (m_we) begin
            chk({tag, ".waddr"}, 64'(waddr_b_o), 64'(m_waddr));
            chk({tag, ".wdata"}, 64'(wdata_b_o), 64'(m_wdata));
        end
    endtask

    // One clock: drive inputs, advance the model, check outputs 1 time unit after the edge.
    task automatic step(input string tag, input logic iv, input logic [4:0] ird,
                        input logic rv, input logic [31:0] rdat);
        bit was_empty, was_full;
        logic [4:0] h;
        issue_valid_i = iv; issue_rd_i = ird; rsp_valid_i = rv; rsp_data_i = rdat;
        was_empty = (mq.size() == 0);
        was_full  = (mq.size() == DEPTH);
        m_we  = 1'b0;
        m_err = rv && was_empty;
        if (rv && !was_empty) begin
            h = mq.pop_front();
            m_we = (h != 0);
            if (m_we) begin
                m_waddr = h;
                m_wdata = rdat;
            end
        end
        if (iv && !was_full) mq.push_back(ird);
        @(posedge clk); #1;
        issue_valid_i = 1'b0; rsp_valid_i = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 5'd0, 1'b0, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all("in_reset");
        rst_n = 1'b1;
        idle("post_reset");

        // Single load to x5
        step("t2_issue", 1'b1, 5'd5, 1'b0, 32'd0);
        chk("t2_busy5_pending", 64'(busy_o[5]), 64'd1);
        step("t2_rsp", 1'b0, 5'd0, 1'b1, 32'hDEADBEEF);
        chk("t2_we", 64'(we_b_o), 64'd1);
        chk("t2_waddr", 64'(waddr_b_o), 64'd5);
        chk("t2_wdata", 64'(wdata_b_o), 64'hDEADBEEF);
        chk("t2_busy5_write", 64'(busy_o[5]), 64'd1);
        idle("t2_after");
        chk("t2_busy5_clear", 64'(busy_o[5]), 64'd0);

        // Fill, over-issue, drain in order
        for (int i = 1; i <= 4; i++) step("t3_fill", 1'b1, 5'(i), 1'b0, 32'd0);
        chk("t3_not_ready", 64'(issue_ready_o), 64'd0);
        step("t3_overissue", 1'b1, 5'd9, 1'b0, 32'd0);
        chk("t3_busy9_clear", 64'(busy_o[9]), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            step("t3_drain", 1'b0, 5'd0, 1'b1, 32'(i * 32'h11));
            chk("t3_waddr_order", 64'(waddr_b_o), 64'(i));
        end
        idle("t3_empty");
        chk("t3_count0", 64'(count_o), 64'd0);

        // Full queue with simultaneous issue and response
        for (int i = 0; i < 4; i++) step("t4_fill", 1'b1, 5'(10 + i), 1'b0, 32'd0);
        step("t4_full_both", 1'b1, 5'd20, 1'b1, 32'hA5A5_0001);
        chk("t4_count3", 64'(count_o), 64'd3);
        step("t4_both_at3", 1'b1, 5'd21, 1'b1, 32'hA5A5_0002);
        chk("t4_count_stays3", 64'(count_o), 64'd3);
        for (int i = 0; i < 3; i++) step("t4_drain", 1'b0, 5'd0, 1'b1, 32'(100 + i));
        idle("t4_empty");

        // Same rd twice
        step("t5_i1", 1'b1, 5'd7, 1'b0, 32'd0);
        step("t5_i2", 1'b1, 5'd7, 1'b0, 32'd0);
        step("t5_r1", 1'b0, 5'd0, 1'b1, 32'h0000_0701);
        idle("t5_mid");
        chk("t5_busy7_held", 64'(busy_o[7]), 64'd1);
        step("t5_r2", 1'b0, 5'd0, 1'b1, 32'h0000_0702);
        idle("t5_done");
        chk("t5_busy7_clear", 64'(busy_o[7]), 64'd0);

        // Errors and x0
        step("t6_err", 1'b0, 5'd0, 1'b1, 32'h1234);
        chk("t6_err_pulse", 64'(err_o), 64'd1);
        chk("t6_err_no_we", 64'(we_b_o), 64'd0);
        idle("t6_err_gone");
        step("t6_issue_rsp_empty", 1'b1, 5'd3, 1'b1, 32'h5678);
        chk("t6_err_same_cycle", 64'(err_o), 64'd1);
        chk("t6_issue_kept", 64'(count_o), 64'd1);
        step("t6_pop3", 1'b0, 5'd0, 1'b1, 32'h9999);
        step("t6_issue_x0", 1'b1, 5'd0, 1'b0, 32'd0);
        step("t6_rsp_x0", 1'b0, 5'd0, 1'b1, 32'hFFFF);
        chk("t6_x0_no_we", 64'(we_b_o), 64'd0);
        chk("t6_x0_popped", 64'(count_o), 64'd0);

        // Random traffic with small rd range to force collisions
        for (int n = 0; n < 400; n++) begin
            step("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 2) != 0), $urandom);
        end

        // Reset mid-burst with 3 entries and a write on port B
        while (mq.size() != 0) step("pre_rst_drain", 1'b0, 5'd0, 1'b1, 32'd0);
        step("t1_a", 1'b1, 5'd1, 1'b0, 32'd0);
        step("t1_b", 1'b1, 5'd2, 1'b0, 32'd0);
        step("t1_c", 1'b1, 5'd3, 1'b0, 32'd0);
        step("t1_d", 1'b1, 5'd4, 1'b1, 32'hCAFE);
        chk("t1_pre_count", 64'(count_o), 64'd3);
        chk("t1_pre_we", 64'(we_b_o), 64'd1);
        rst_n = 1'b0;
        #1;
        mq.delete(); m_we = 1'b0; m_err = 1'b0;
        chk("t1_rst_count", 64'(count_o), 64'd0);
        chk("t1_rst_busy", 64'(busy_o), 64'd0);
        chk("t1_rst_we", 64'(we_b_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle("t1_after");
        step("t1_reuse", 1'b1, 5'd6, 1'b0, 32'd0);
        step("t1_reuse_rsp", 1'b0, 5'd0, 1'b1, 32'h600D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
